// File: rtl/pixel_timing_unit_if.sv
// Bus between the board-clock side and the screen logic: divider control,
// divided clock, and the pixel index to (x, y) split. tick exists only with PTU_TICK_EN.
interface pixel_timing_unit_if #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 13
);
  logic [CNT_W-1:0] count_in;
  logic [IDX_W-1:0] pixel_index;
  logic             out_clk;
  logic [IDX_W-1:0] x;
  logic [IDX_W-1:0] y;
`ifdef PTU_TICK_EN
  logic             tick;
`endif

  modport master (
    output count_in,
    output pixel_index,
    input  out_clk,
    input  x,
`ifdef PTU_TICK_EN
    input  tick,
`endif
    input  y
  );

  modport slave (
    input  count_in,
    input  pixel_index,
    output out_clk,
    output x,
`ifdef PTU_TICK_EN
    output tick,
`endif
    output y
  );
endinterface

// File: rtl/pixel_timing_unit.sv
// Programmable 50% clock divider plus OLED pixel index -> (x, y) converter.
// Optional macro PTU_TICK_EN adds a one-cycle tick on each rising edge of out_clk.
module pixel_timing_unit #(
  parameter int CNT_W = 32,
  parameter int SCR_W = 96,
  parameter int SCR_H = 64,
  parameter int IDX_W = 13
) (
  input logic                basys_clk,
  input logic                resetn,
  pixel_timing_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] SCR_W_I = IDX_W'(SCR_W);

  if (SCR_W * SCR_H > (1 << IDX_W)) begin : g_geom_check
    $error("pixel_timing_unit: SCR_W*SCR_H does not fit in IDX_W bits");
  end

  // Constant divisor, so both operators reduce to combinational logic.
  function automatic logic [2*IDX_W-1:0] split_index(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] col;
    logic [IDX_W-1:0] row;
    col = idx % SCR_W_I;
    row = idx / SCR_W_I;
    return {row, col};
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic             out_clk_p0;
  logic             wrap;

  // >= rather than == so a count_in lowered below cnt wraps on the next edge.
  assign wrap = (cnt_p0 >= bus.count_in);

  // Stage p0: divider counter and registered output clock
  always_ff @(posedge basys_clk) begin
    if (!resetn) begin
      cnt_p0     <= '0;
      out_clk_p0 <= 1'b0;
    end else if (wrap) begin
      cnt_p0     <= '0;
      out_clk_p0 <= ~out_clk_p0;
    end else begin
      cnt_p0     <= cnt_p0 + CNT_ONE;
    end
  end

  assign bus.out_clk = out_clk_p0;

`ifdef PTU_TICK_EN
  logic tick_p0;

  // Stage p0: tick marks the wrap that takes out_clk from 0 to 1
  always_ff @(posedge basys_clk) begin
    if (!resetn) begin
      tick_p0 <= 1'b0;
    end else begin
      tick_p0 <= wrap & ~out_clk_p0;
    end
  end

  assign bus.tick = tick_p0;
`endif

  assign {bus.y, bus.x} = split_index(bus.pixel_index);

endmodule

// File: tb/tb_pixel_timing_unit.sv
// Bench for pixel_timing_unit: time-based divider model checked every cycle,
// literal timing/coordinate expectations, and a randomized control phase.
module tb_pixel_timing_unit;

  logic basys_clk;
  logic resetn;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  pixel_timing_unit_if #(.CNT_W(32), .IDX_W(13)) bus ();

  pixel_timing_unit #(.CNT_W(32), .SCR_W(96), .SCR_H(64), .IDX_W(13)) dut (
    .basys_clk (basys_clk),
    .resetn    (resetn),
    .bus       (bus)
  );

  initial basys_clk = 1'b0;
  always #5 basys_clk = ~basys_clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: out_clk toggles on the edge where the number of non-reset edges
  // since the last toggle (or reset) has exceeded count_in.
  longint m_cyc = 0;
  longint m_last = 0;
  logic   m_out = 1'b0;
  logic   m_tick = 1'b0;

  always @(posedge basys_clk) begin
    m_cyc++;
    if (!resetn) begin
      m_out  = 1'b0;
      m_tick = 1'b0;
      m_last = m_cyc;
    end else if (m_cyc - m_last - 1 >= longint'({32'd0, bus.count_in})) begin
      m_out  = ~m_out;
      m_tick = m_out;
      m_last = m_cyc;
    end else begin
      m_tick = 1'b0;
    end
  end

  always @(negedge basys_clk) begin
    if (chk_en) begin
      chk("model_out_clk", {63'd0, bus.out_clk}, {63'd0, m_out});
`ifdef PTU_TICK_EN
      chk("model_tick", {63'd0, bus.tick}, {63'd0, m_tick});
`endif
    end
  end

  task automatic step();
    @(posedge basys_clk);
    #1;
  endtask

  task automatic wait_out(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.out_clk !== lvl && n < limit);
  endtask

  task automatic do_reset(input logic [31:0] cnt);
    resetn = 1'b0;
    bus.count_in = cnt;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    logic prev;
    int col;
    int row;
    logic [12:0] idx;
    logic [12:0] lit_idx [5] = '{13'd0, 13'd95, 13'd96, 13'd6143, 13'd8191};
    int          lit_x   [5] = '{0, 95, 0, 95, 31};
    int          lit_y   [5] = '{0, 0, 1, 63, 85};

    resetn = 1'b0;
    bus.count_in = 32'd7;
    bus.pixel_index = '0;
    step();
    chk_en = 1;
    step();
    step();
    chk("reset_out_clk", {63'd0, bus.out_clk}, 64'd0);
`ifdef PTU_TICK_EN
    chk("reset_tick", {63'd0, bus.tick}, 64'd0);
`endif

    // count_in=7: first rise after 8 edges, then 8 high / 8 low
    resetn = 1'b1;
    wait_out(1'b1, 100, n);
    chk("first_rise_c7", n, 8);
    for (int p = 0; p < 10; p++) begin
      wait_out(1'b0, 100, n);
      chk("high_len_c7", n, 8);
      wait_out(1'b1, 100, n);
      chk("low_len_c7", n, 8);
    end

    // count_in=0: toggle on every edge
    bus.count_in = 32'd0;
    wait_out(~bus.out_clk, 20, n);
    for (int i = 0; i < 12; i++) begin
      prev = bus.out_clk;
      step();
      chk("toggle_c0", {63'd0, bus.out_clk}, {63'd0, ~prev});
    end

    // count_in 100 -> 3 with cnt near 50: wrap next edge, then period 8
    do_reset(32'd100);
    repeat (50) step();
    chk("no_toggle_yet", {63'd0, bus.out_clk}, 64'd0);
    bus.count_in = 32'd3;
    wait_out(1'b1, 20, n);
    chk("shrink_wrap", n, 1);
    for (int p = 0; p < 4; p++) begin
      wait_out(1'b0, 20, n);
      chk("high_len_c3", n, 4);
      wait_out(1'b1, 20, n);
      chk("low_len_c3", n, 4);
    end

    // reset mid-period with out_clk high, then cold-start timing
    do_reset(32'd7);
    wait_out(1'b1, 100, n);
    chk("first_rise_pre", n, 8);
    repeat (3) step();
    chk("mid_high", {63'd0, bus.out_clk}, 64'd1);
    resetn = 1'b0;
    step();
    chk("mid_reset_out", {63'd0, bus.out_clk}, 64'd0);
    resetn = 1'b1;
    wait_out(1'b1, 100, n);
    chk("restart_rise", n, 8);

    // randomized control: count_in changes (incl. all-ones) and reset pulses
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) resetn = 1'b0;
      else if (!resetn && $urandom_range(0, 2) == 0) resetn = 1'b1;
      if ($urandom_range(0, 39) == 0)
        bus.count_in = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12));
      step();
    end
    resetn = 1'b1;

    // coordinate converter: literals, with clock and reset irrelevant
    resetn = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.pixel_index = lit_idx[k];
      #1;
      chk("lit_x", {51'd0, bus.x}, 64'(lit_x[k]));
      chk("lit_y", {51'd0, bus.y}, 64'(lit_y[k]));
    end
    resetn = 1'b1;

    // raster sweep over the visible panel
    col = 0;
    row = 0;
    for (int i = 0; i < 6144; i++) begin
      bus.pixel_index = 13'(i);
      #1;
      chk("sweep_x", {51'd0, bus.x}, 64'(col));
      chk("sweep_y", {51'd0, bus.y}, 64'(row));
      chk("sweep_bounds", {63'd0, (bus.x <= 13'd95) && (bus.y <= 13'd63)}, 64'd1);
      col++;
      if (col == 96) begin
        col = 0;
        row++;
      end
    end

    // random indices across the full 13-bit range, unclamped
    for (int i = 0; i < 300; i++) begin
      idx = 13'($urandom_range(0, 8191));
      bus.pixel_index = idx;
      #1;
      chk("rand_recombine", 64'(bus.x) + 64'd96 * 64'(bus.y), {51'd0, idx});
      chk("rand_x_lt_w", {63'd0, bus.x < 13'd96}, 64'd1);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
